// File: rtl/gpio_event_latch.sv
// Multi-channel GPIO input conditioner: synchronizer, debounce filter,
// qualified edge strobe, sticky event latch and combined interrupt.
module gpio_event_latch #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     din,
    input  logic [2*N_CH-1:0]   edge_mode,
    input  logic [N_CH-1:0]     clr,
    input  logic [N_CH-1:0]     irq_en,
    output logic [N_CH-1:0]     dout,
    output logic                any_high,
    output logic                all_high,
    output logic [N_CH-1:0]     edge_pulse,
    output logic [N_CH-1:0]     latched,
    output logic                irq
);

    // Counter only needs to reach DEBOUNCE-1.
    localparam int CW = (DEBOUNCE <= 1) ? 1 : $clog2(DEBOUNCE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] chain;
        logic                   sync_q;
        logic                   upd;
        logic                   dout_q;
        logic                   pulse_q;

        assign sync_q = chain[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], din[i]};
            end
        end

        if (DEBOUNCE == 0) begin : g_bypass
            assign upd = (sync_q != dout_q);
        end else begin : g_filter
            logic [CW-1:0] cnt;

            assign upd = (sync_q != dout_q) && (cnt == CW'(DEBOUNCE - 1));

            // Any return to the accepted level restarts the qualification window.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                end else if ((sync_q == dout_q) || upd) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= upd & (sync_q ? edge_mode[2*i] : edge_mode[2*i+1]);
                if (upd) begin
                    dout_q <= sync_q;
                end
            end
        end

        assign dout[i]       = dout_q;
        assign edge_pulse[i] = pulse_q;
    end

    // A new event outranks a concurrent clear so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            latched  <= '0;
            irq      <= 1'b0;
            any_high <= 1'b0;
            all_high <= 1'b0;
        end else begin
            latched  <= (latched & ~clr) | edge_pulse;
            irq      <= |(latched & irq_en);
            any_high <= |dout;
            all_high <= &dout;
        end
    end

endmodule

// File: tb/tb_gpio_event_latch.sv
// Scoreboard bench for gpio_event_latch: stimulus queues timed expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_gpio_event_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic [7:0] edge_mode;
    logic [3:0] clr;
    logic [3:0] irq_en;
    logic [3:0] dout;
    logic       any_high;
    logic       all_high;
    logic [3:0] edge_pulse;
    logic [3:0] latched;
    logic       irq;

    logic [0:0] din_b;
    logic [1:0] edge_mode_b;
    logic [0:0] clr_b;
    logic [0:0] irq_en_b;
    logic [0:0] dout_b;
    logic       any_b;
    logic       all_b;
    logic [0:0] pulse_b;
    logic [0:0] latched_b;
    logic       irq_b;

    always #5 clk = ~clk;

    gpio_event_latch #(.N_CH(4), .SYNC_STAGES(2), .DEBOUNCE(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .edge_mode  (edge_mode),
        .clr        (clr),
        .irq_en     (irq_en),
        .dout       (dout),
        .any_high   (any_high),
        .all_high   (all_high),
        .edge_pulse (edge_pulse),
        .latched    (latched),
        .irq        (irq)
    );

    gpio_event_latch #(.N_CH(1), .SYNC_STAGES(2), .DEBOUNCE(0)) u_dut_nodb (
        .clk        (clk),
        .reset      (reset),
        .din        (din_b),
        .edge_mode  (edge_mode_b),
        .clr        (clr_b),
        .irq_en     (irq_en_b),
        .dout       (dout_b),
        .any_high   (any_b),
        .all_high   (all_b),
        .edge_pulse (pulse_b),
        .latched    (latched_b),
        .irq        (irq_b)
    );

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            0:       return {28'd0, dout};
            1:       return {31'd0, any_high};
            2:       return {31'd0, all_high};
            3:       return {28'd0, edge_pulse};
            4:       return {28'd0, latched};
            5:       return {31'd0, irq};
            6:       return {31'd0, dout_b};
            default: return {31'd0, pulse_b};
        endcase
    endfunction

    function automatic string signame(input int sig);
        case (sig)
            0:       return "dout";
            1:       return "any_high";
            2:       return "all_high";
            3:       return "edge_pulse";
            4:       return "latched";
            5:       return "irq";
            6:       return "dout_nodb";
            default: return "edge_pulse_nodb";
        endcase
    endfunction

    task automatic exp_at(input int dly, input int sig, input logic [31:0] v);
        exp_t e;
        e.due = cyc + dly;
        e.sig = sig;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: retire every expectation that has come due this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [31:0] act;
                act = sample(q[i].sig);
                n_chk++;
                if (act !== q[i].exp || q[i].due < cyc) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h",
                             signame(q[i].sig), cyc, act, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        din         = 4'b0000;
        clr         = 4'b0000;
        irq_en      = 4'b0001;
        edge_mode   = 8'b11_10_11_01;
        din_b       = 1'b0;
        edge_mode_b = 2'b11;
        clr_b       = 1'b0;
        irq_en_b    = 1'b1;

        tick(1);
        for (int s = 0; s < 8; s++) exp_at(2, s, 0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // Rising step on ch0 (mode 01) and on the bypass instance.
        din = 4'b0001; din_b = 1'b1;
        exp_at(2, 6, 0); exp_at(3, 6, 1); exp_at(3, 7, 1); exp_at(4, 7, 0);
        exp_at(5, 0, 0); exp_at(6, 0, 1); exp_at(6, 3, 1); exp_at(6, 1, 0);
        exp_at(7, 3, 0); exp_at(7, 4, 1); exp_at(7, 1, 1); exp_at(7, 5, 0);
        exp_at(8, 5, 1);
        tick(10);

        // Three-cycle glitch on ch1 is rejected.
        din = 4'b0011;
        exp_at(6, 0, 4'b0001); exp_at(9, 0, 4'b0001); exp_at(6, 3, 0); exp_at(9, 4, 4'b0001);
        tick(3);
        din = 4'b0001;
        tick(10);

        // Clear ch0, then clear coincident with a new ch0 pulse.
        clr = 4'b0001;
        exp_at(1, 4, 0); exp_at(2, 5, 0);
        tick(1);
        clr = 4'b0000;
        tick(2);
        din = 4'b0000;
        exp_at(6, 0, 0); exp_at(6, 3, 0);
        tick(10);
        din = 4'b0001;
        exp_at(6, 3, 4'b0001); exp_at(7, 4, 4'b0001); exp_at(8, 4, 0);
        exp_at(8, 5, 1); exp_at(9, 5, 0);
        tick(6);
        clr = 4'b0001;
        tick(2);
        clr = 4'b0000;
        tick(4);

        // ch2 in falling-only mode.
        din = 4'b0101;
        exp_at(6, 0, 4'b0101); exp_at(6, 3, 0); exp_at(7, 4, 0);
        tick(10);
        din = 4'b0001;
        exp_at(6, 0, 4'b0001); exp_at(6, 3, 4'b0100); exp_at(7, 3, 0);
        exp_at(7, 4, 4'b0100); exp_at(8, 5, 0);
        tick(8);
        irq_en = 4'b0101;
        exp_at(1, 5, 1);
        tick(2);
        irq_en = 4'b0001;
        exp_at(1, 5, 0); exp_at(1, 4, 4'b0100);
        tick(4);

        // All channels high, then ch3 drops.
        din = 4'b1111;
        exp_at(6, 0, 4'b1111); exp_at(6, 3, 4'b1010); exp_at(6, 2, 0);
        exp_at(7, 2, 1); exp_at(7, 1, 1);
        tick(10);
        din = 4'b0111;
        exp_at(6, 0, 4'b0111); exp_at(6, 3, 4'b1000); exp_at(6, 2, 1);
        exp_at(7, 2, 0); exp_at(7, 1, 1);
        tick(10);

        // Mode 00 on ch1 never pulses.
        edge_mode = 8'b11_10_00_01;
        din = 4'b0101;
        exp_at(6, 0, 4'b0101); exp_at(6, 3, 0);
        tick(10);

        // Reset in the middle of a ch3 debounce; inputs held through release.
        din = 4'b1101;
        tick(4);
        reset = 1'b1;
        exp_at(1, 0, 0); exp_at(1, 1, 0); exp_at(1, 3, 0); exp_at(1, 4, 0); exp_at(1, 5, 0);
        tick(1);
        reset = 1'b0;
        exp_at(5, 0, 0); exp_at(6, 0, 4'b1101); exp_at(6, 3, 4'b1001);
        tick(12);

        for (int g = 0; g < 100 && q.size() > 0; g++) tick(1);
        if (q.size() > 0) begin
            $display("FAIL drain pending=%0d required=0", q.size());
            n_chk  += q.size();
            n_fail += q.size();
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_event_latch.md
GPIO_EVENT_LATCH -- requirements
Module: gpio_event_latch

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel; legal range 2..4.
REQ-003 Parameter DEBOUNCE, default 4: cycles a new level must persist before acceptance; 0 = debounce bypassed; legal range 0..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  N_CH  asynchronous raw channel inputs.
REQ-007 edge_mode  input  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clr  input  N_CH  per-channel clear of latched; level-sensitive, sampled each cycle.
REQ-009 irq_en  input  N_CH  per-channel interrupt enable.
REQ-010 dout  output  N_CH  debounced channel level.
REQ-011 any_high  output  1  registered OR of dout.
REQ-012 all_high  output  1  registered AND of dout.
REQ-013 edge_pulse  output  N_CH  one-cycle qualified edge strobe.
REQ-014 latched  output  N_CH  sticky event flag.
REQ-015 irq  output  1  registered OR of (latched AND irq_en).

Function
REQ-016 Each din bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "sync[i]".
REQ-017 DEBOUNCE>=1: per-channel counter SHALL increment each cycle sync[i]!=dout[i], clear to 0 whenever sync[i]==dout[i], and on the cycle it equals DEBOUNCE-1 with sync[i]!=dout[i] SHALL load dout[i]<=sync[i] and clear to 0.
REQ-018 DEBOUNCE=0: dout[i] SHALL register sync[i] every cycle.
REQ-019 Latency, din step held stable to dout change: SYNC_STAGES+DEBOUNCE cycles (DEBOUNCE>=1); SYNC_STAGES+1 cycles (DEBOUNCE=0).
REQ-020 A glitch on sync[i] shorter than DEBOUNCE cycles SHALL NOT change dout[i]; the counter restarts from 0 on each return to the stable level.
REQ-021 Counter width SHALL be the minimum that holds DEBOUNCE-1; no wrap-around is reachable.
REQ-022 edge_pulse[i] SHALL be high for exactly the first cycle dout[i] shows a new value, when that transition matches edge_mode[i] at the cycle of the update (01 rise, 10 fall, 11 either); mode 00 SHALL never pulse.
REQ-023 edge_mode changes SHALL take effect on the next dout transition only; no retroactive pulse or latch.
REQ-024 latched[i] SHALL set the cycle after edge_pulse[i] and hold until cleared.
REQ-025 clr[i] high SHALL clear latched[i] on the next cycle; held clr keeps it clear.
REQ-026 Simultaneous edge_pulse[i] and clr[i]: set wins; latched[i]=1 next cycle (no lost event).
REQ-027 irq SHALL follow latched/irq_en with one cycle latency; deasserting irq_en[i] drops its irq contribution next cycle without clearing latched[i].
REQ-028 any_high and all_high SHALL update one cycle after dout.
REQ-029 Channels SHALL be fully independent; no cross-channel state.

Reset
REQ-030 While reset is high at a rising clk edge: sync chains, counters, dout, edge_pulse, latched, any_high, all_high, irq SHALL all be 0.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count; reset dominates clr and edges.
REQ-032 A din held high through reset release SHALL be treated as a rising transition after the REQ-019 latency.

Verification
REQ-033 N_CH=4, DEBOUNCE=4, SYNC_STAGES=2, mode 01 on ch0: din[0] 0->1 held -> dout[0]=1 at cycle 6, edge_pulse[0] one cycle at 6, latched[0]=1 at 7, irq=1 at 8 with irq_en[0]=1.
REQ-034 din[1] high for 3 cycles then low, DEBOUNCE=4 -> dout[1], edge_pulse[1], latched[1] stay 0.
REQ-035 Mode 10 on ch2: rising step -> no pulse; following falling step -> edge_pulse[2] one cycle, latched[2]=1.
REQ-036 clr[0] asserted the same cycle as edge_pulse[0] -> latched[0]=1 next cycle; clr[0] alone next -> latched[0]=0, irq=0 one cycle later.
REQ-037 din=4'b1111 -> all_high=1, any_high=1; din[3]->0 -> all_high=0 one cycle after dout[3] falls.
REQ-038 DEBOUNCE=0 build: din[0] step -> dout[0] at cycle 3; reset mid-count (DEBOUNCE=4) -> all outputs 0, count restarts from 0 after release.
